// File: rtl/procb_pkg.sv
// procb_pkg: shared defaults, derived widths and error-flag bit positions for the procb ring buffer
package procb_pkg;
    localparam int N_THREADS_DEF = 16;
    localparam int N_RECORDS_DEF = 8;
    localparam int D_WIDTH_DEF   = 32;
    localparam int T_WIDTH_DEF   = $clog2(N_THREADS_DEF);
    localparam int A_WIDTH_DEF   = $clog2(N_RECORDS_DEF);
    localparam int ERR_WR_FULL   = 0;
    localparam int ERR_RD_EMPTY  = 1;
    typedef logic [1:0] err_t;
endpackage

// File: rtl/procb_thread_ptr.sv
// procb_thread_ptr: write/read pointers and occupancy count of one thread queue
module procb_thread_ptr
    import procb_pkg::*;
#(
    parameter int N_RECORDS = N_RECORDS_DEF,
    parameter int AW        = $clog2(N_RECORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_wr_req,
    input  logic          i_rd_req,
    input  logic          i_flush,
    output logic [AW-1:0] o_wr_idx,
    output logic [AW-1:0] o_rd_ptr,
    output logic [AW:0]   o_cnt,
    output logic          o_wr_acc,
    output logic          o_wr_err,
    output logic          o_rd_err
);
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_cnt;
    logic          w_empty;
    logic          w_full;
    logic          w_rd_acc;

    // Accept/reject decisions; a flush or a concurrent pop frees room for a write to a full queue
    always_comb begin
        w_empty  = r_cnt == '0;
        w_full   = r_cnt == (AW+1)'(N_RECORDS);
        w_rd_acc = i_rd_req & ~i_flush & ~w_empty;
        o_wr_acc = i_wr_req & (~w_full | w_rd_acc | i_flush);
        o_wr_err = i_wr_req & ~o_wr_acc;
        o_rd_err = i_rd_req & ~i_flush & w_empty;
        o_wr_idx = i_flush ? '0 : r_wr_ptr;
    end

    // Pointer/count update; a flush restarts the queue at slot 0, keeping any concurrent write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= o_wr_acc ? AW'(1) : '0;
            r_rd_ptr <= '0;
            r_cnt    <= o_wr_acc ? (AW+1)'(1) : '0;
        end else begin
            if (o_wr_acc)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd_acc)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(o_wr_acc) - (AW+1)'(w_rd_acc);
        end
    end

    assign o_rd_ptr = r_rd_ptr;
    assign o_cnt    = r_cnt;
endmodule

// File: rtl/procb_ring_buf.sv
// procb_ring_buf: per-thread circular record queues in shared distributed RAM, FWFT read port
// Optional lookahead read cursor enabled by macro PROCB_LOOKAHEAD_EN.
module procb_ring_buf
    import procb_pkg::*;
#(
    parameter int N_THREADS = N_THREADS_DEF,
    parameter int N_RECORDS = N_RECORDS_DEF,
    parameter int D_WIDTH   = D_WIDTH_DEF
) (
    input  logic                         CLK,
    input  logic                         rst_n,
    input  logic [$clog2(N_THREADS)-1:0] wr_thread_num,
    input  logic                         wr_en,
    input  logic [D_WIDTH-1:0]           din,
    output logic [$clog2(N_RECORDS):0]   wr_cnt,
    output logic                         wr_full,
    input  logic [$clog2(N_THREADS)-1:0] rd_thread_num,
    input  logic                         rd_en,
    input  logic                         rd_rst,
    output logic [D_WIDTH-1:0]           dout,
    output logic                         empty,
    output logic                         aempty,
    output logic [1:0]                   err
`ifdef PROCB_LOOKAHEAD_EN
    ,
    input  logic                         lookup_en,
    output logic                         lookup_empty,
    output logic [D_WIDTH-1:0]           lookup_dout
`endif
);
    localparam int TW = $clog2(N_THREADS);
    localparam int AW = $clog2(N_RECORDS);

    logic [AW-1:0]      w_wr_idx [N_THREADS];
    logic [AW-1:0]      w_rd_ptr [N_THREADS];
    logic [AW:0]        w_cnt    [N_THREADS];
    logic [N_THREADS-1:0] w_wr_acc;
    logic [N_THREADS-1:0] w_wr_err;
    logic [N_THREADS-1:0] w_rd_err;
    logic [AW:0]        w_rd_cnt;
    logic [D_WIDTH-1:0] r_mem [N_THREADS*N_RECORDS];
    err_t               r_err;

    for (genvar t = 0; t < N_THREADS; t++) begin : g_thr
        procb_thread_ptr #(.N_RECORDS(N_RECORDS)) u_ptr (
            .clk      (CLK),
            .rst_n    (rst_n),
            .i_wr_req (wr_en && wr_thread_num == TW'(t)),
            .i_rd_req (rd_en && rd_thread_num == TW'(t)),
            .i_flush  (rd_rst && rd_thread_num == TW'(t)),
            .o_wr_idx (w_wr_idx[t]),
            .o_rd_ptr (w_rd_ptr[t]),
            .o_cnt    (w_cnt[t]),
            .o_wr_acc (w_wr_acc[t]),
            .o_wr_err (w_wr_err[t]),
            .o_rd_err (w_rd_err[t])
        );
    end

    // Single write port into the record store; contents are intentionally not reset
    always_ff @(posedge CLK) begin
        if (|w_wr_acc)
            r_mem[{wr_thread_num, w_wr_idx[wr_thread_num]}] <= din;
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= '0;
        end else begin
            r_err[ERR_WR_FULL]  <= r_err[ERR_WR_FULL] | (|w_wr_err);
            r_err[ERR_RD_EMPTY] <= r_err[ERR_RD_EMPTY] | (|w_rd_err);
        end
    end

    // Status and first-word fall-through data of the addressed queues
    always_comb begin
        w_rd_cnt = w_cnt[rd_thread_num];
        wr_cnt   = w_cnt[wr_thread_num];
        wr_full  = wr_cnt == (AW+1)'(N_RECORDS);
        dout     = r_mem[{rd_thread_num, w_rd_ptr[rd_thread_num]}];
        empty    = w_rd_cnt == '0;
        aempty   = w_rd_cnt == (AW+1)'(1);
        err      = r_err;
    end

`ifdef PROCB_LOOKAHEAD_EN
    logic [TW-1:0] r_la_thread;
    logic [AW:0]   r_la_off;
    logic [AW:0]   w_la_off;
    logic [AW-1:0] w_la_ptr;
    logic          w_la_clr;

    // Offset is meaningless once the read thread changes, so it is forced to zero that same cycle
    always_comb begin
        w_la_off     = (rd_thread_num != r_la_thread) ? '0 : r_la_off;
        w_la_ptr     = w_rd_ptr[rd_thread_num] + w_la_off[AW-1:0];
        w_la_clr     = rd_en | rd_rst | (wr_en & (wr_thread_num == rd_thread_num));
        lookup_empty = w_la_off == w_rd_cnt;
        lookup_dout  = r_mem[{rd_thread_num, w_la_ptr}];
    end

    // Lookahead cursor: restarts at the head on any change to the read queue, else advances on lookup_en
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_la_thread <= '0;
            r_la_off    <= '0;
        end else begin
            r_la_thread <= rd_thread_num;
            r_la_off    <= w_la_clr ? '0 :
                           (lookup_en & ~lookup_empty) ? w_la_off + (AW+1)'(1) : w_la_off;
        end
    end
`endif
endmodule

// File: doc/procb_ring_buf.md
PROCB_RING_BUF -- requirements
Module: procb_ring_buf

Interface
REQ-001 SHALL have parameter N_THREADS, default 16, number of independent thread queues (power of 2, >=2).
REQ-002 SHALL have parameter N_RECORDS, default 8, records per thread (power of 2, >=2); A = log2(N_RECORDS).
REQ-003 SHALL have parameter D_WIDTH, default 32, procb record width.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 CLK  input  1  sole clock, rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 wr_thread_num  input  log2(N_THREADS)  thread written.
REQ-008 wr_en  input  1  write din to wr_thread_num queue.
REQ-009 din  input  D_WIDTH  record written.
REQ-010 wr_cnt  output  A+1  combinational record count of wr_thread_num queue, 0..N_RECORDS.
REQ-011 wr_full  output  1  combinational, wr_cnt == N_RECORDS.
REQ-012 rd_thread_num  input  log2(N_THREADS)  thread read.
REQ-013 rd_en  input  1  pop head of rd_thread_num queue.
REQ-014 rd_rst  input  1  flush rd_thread_num queue.
REQ-015 dout  output  D_WIDTH  combinational head record of rd_thread_num queue (first-word fall-through).
REQ-016 empty  output  1  combinational, rd_thread_num queue count == 0.
REQ-017 aempty  output  1  combinational, rd_thread_num queue count == 1.
REQ-018 err  output  2  sticky flags: bit0 write to full queue, bit1 read of empty queue.

Function
REQ-019 Each thread SHALL own a circular queue: A-bit wr_ptr, A-bit rd_ptr, (A+1)-bit count; pointers wrap N_RECORDS-1 -> 0.
REQ-020 Accepted write SHALL store din at {wr_thread_num, wr_ptr} and increment wr_ptr and count on the same edge; data readable on dout the next cycle.
REQ-021 Write while full SHALL be dropped, pointers unchanged, err[0] set.
REQ-022 rd_en while not empty SHALL increment rd_ptr and decrement count; rd_en while empty SHALL be ignored and set err[1].
REQ-023 Write and read of the same thread in one cycle SHALL leave count unchanged; write to a full queue with a concurrent read of it SHALL be accepted; read of an empty queue with a concurrent write SHALL be ignored (err[1] set, write accepted).
REQ-024 Write and read of different threads SHALL proceed independently in the same cycle.
REQ-025 rd_rst SHALL zero wr_ptr, rd_ptr, count of rd_thread_num, overriding rd_en; a concurrent write to the same thread SHALL land at index 0, leaving count = 1.
REQ-026 err SHALL clear only on reset.

Reset
REQ-027 On rst_n low, all pointers, counts, err and lookahead state SHALL clear asynchronously; record memory is not reset.
REQ-028 After reset: wr_cnt = 0, wr_full = 0, empty = 1, aempty = 0, err = 0, lookup_empty = 1.

Configuration
REQ-029 Macro PROCB_LOOKAHEAD_EN SHALL add ports lookup_en (input 1), lookup_empty (output 1), lookup_dout (output D_WIDTH).
REQ-030 With it: per-read-port lookahead pointer and offset; offset SHALL reset to 0 (pointer = rd_ptr) when rd_thread_num differs from its previous-cycle value, on rd_en, on rd_rst, or on write to rd_thread_num; lookup_en while not lookup_empty SHALL increment pointer and offset; lookup_empty = (offset == count); lookup_dout = record at lookahead pointer.
REQ-031 Without it: none of these ports or registers SHALL exist; all other behaviour identical.

Structure
REQ-032 Package procb_pkg SHALL hold default N_THREADS/N_RECORDS/D_WIDTH, derived address widths and err bit indices.
REQ-033 Per-thread pointer/count logic SHALL be sub-module procb_thread_ptr, instanced N_THREADS times; memory SHALL be distributed RAM, one write port.

Verification
REQ-034 Reset, write thread 3 values 0xA0..0xA7 (N_RECORDS=8) -> wr_cnt 8, wr_full 1; 9th write dropped, err = 2'b01.
REQ-035 Pop 3 from thread 3, write 0xB0..0xB2 -> wrap; read order 0xA3..0xA7, 0xB0..0xB2, then empty 1.
REQ-036 Thread 5 count 1: same-cycle write 0xC1 and read -> count stays 1, dout 0xC1 next cycle, aempty 1.
REQ-037 rd_rst on thread 2 (count 4) with concurrent write 0xD0 to thread 2 -> count 1, dout 0xD0.
REQ-038 rd_en on empty thread 0 -> err[1] set, pointers unchanged; assert rst_n mid-stream -> err 0, all empty.
REQ-039 PROCB_LOOKAHEAD_EN: thread 1 holds 0xE0..0xE2; three lookup_en -> lookup_dout 0xE0,0xE1,0xE2, then lookup_empty 1; switch rd_thread_num away and back -> lookup_dout 0xE0.
